// File: rtl/pipe_ctrl_pkg.sv
// Shared stall vectors, FSM encoding and default exception vector for pipe_ctrl.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXCP_VECTOR_DEF = 32'h0000_0020;

  typedef enum logic {
    PC_IDLE   = 1'b0,
    PC_MC_RUN = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Down-counter for multi-cycle EX ops: load, decrement, clear, last-cycle detect.
module pipe_ctrl_mc_counter #(
  parameter int MC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [MC_W-1:0] load_val,
  input  logic            dec,
  input  logic            clr,
  output logic            last
);

  logic [MC_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - MC_W'(1);
    end
  end

  // Counter holds the stall cycles still owed after the current one plus one.
  assign last = (cnt_reg == MC_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall arbitration, multi-cycle EX sequencing, flush/redirect.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MC_W        = 4,
  parameter logic [31:0] EXCP_VECTOR = EXCP_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id_i,
  input  logic            stallreq_ex_i,
  input  logic            stallreq_mem_i,
  input  logic            mc_start_i,
  input  logic [MC_W-1:0] mc_len_i,
  input  logic            excp_valid_i,
  input  logic            excp_eret_i,
  input  logic [31:0]     epc_i,
  output logic [5:0]      stall_o,
  output logic            flush_o,
  output logic [31:0]     new_pc_o,
  output logic            mc_busy_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_flush_cnt_o
`endif
);

  pc_state_e state_reg, state_next;
  logic      start_ok;
  logic      cnt_load, cnt_dec, cnt_clr, cnt_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= PC_IDLE;
    else      state_reg <= state_next;
  end

  // A start is only honoured from IDLE, with a non-zero length and no concurrent flush.
  assign start_ok = (state_reg == PC_IDLE) && mc_start_i && (mc_len_i != '0) && !excp_valid_i;

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clr    = 1'b0;
    if (excp_valid_i) begin
      state_next = PC_IDLE;
      cnt_clr    = 1'b1;
    end else begin
      case (state_reg)
        PC_IDLE: begin
          if (start_ok) begin
            cnt_load = 1'b1;
            if (mc_len_i != MC_W'(1)) state_next = PC_MC_RUN;
          end
        end
        PC_MC_RUN: begin
          cnt_dec = 1'b1;
          if (cnt_last) state_next = PC_IDLE;
        end
        default: state_next = PC_IDLE;
      endcase
    end
  end

  // The start cycle is already one stall cycle, so only len-1 remain to be counted.
  pipe_ctrl_mc_counter #(.MC_W(MC_W)) mc_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (mc_len_i - MC_W'(1)),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .last     (cnt_last)
  );

  // Outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    stall_o   = STALL_NONE;
    flush_o   = 1'b0;
    new_pc_o  = 32'h0;
    mc_busy_o = 1'b0;
    if (rst) begin
      mc_busy_o = (state_reg == PC_MC_RUN) || start_ok;
      if (excp_valid_i) begin
        flush_o  = 1'b1;
        new_pc_o = excp_eret_i ? epc_i : EXCP_VECTOR;
      end else if (stallreq_mem_i) begin
        stall_o = STALL_MEM;
      end else if (stallreq_ex_i || mc_busy_o) begin
        stall_o = STALL_EX;
      end else if (stallreq_id_i) begin
        stall_o = STALL_ID;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt_reg, perf_flush_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt_reg <= 32'h0;
      perf_flush_cnt_reg <= 32'h0;
    end else begin
      if (stall_o[0]) perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'h1;
      if (flush_o)    perf_flush_cnt_reg <= perf_flush_cnt_reg + 32'h1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_cnt_reg;
  assign perf_flush_cnt_o = perf_flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a cycle-level behavioural model of the stall rules.
module tb_pipe_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        mc_start = 1'b0;
  logic [3:0]  mc_len = 4'd0;
  logic        excp_valid = 1'b0, excp_eret = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  int          exp_stall_cnt = 0, exp_flush_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: stall cycles still owed by the running multi-cycle op after this one.
  int          busy_left = 0;
  logic [5:0]  e_stall;
  logic        e_flush, e_busy;
  logic [31:0] e_pc;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id),
    .stallreq_ex_i  (stallreq_ex),
    .stallreq_mem_i (stallreq_mem),
    .mc_start_i     (mc_start),
    .mc_len_i       (mc_len),
    .excp_valid_i   (excp_valid),
    .excp_eret_i    (excp_eret),
    .epc_i          (epc),
    .stall_o        (stall),
    .flush_o        (flush),
    .new_pc_o       (new_pc),
    .mc_busy_o      (busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt),
    .perf_flush_cnt_o (perf_flush_cnt)
`endif
  );

  task automatic model_eval();
    logic starting;
    starting = mc_start && (mc_len != 4'd0) && (busy_left == 0) && !excp_valid;
    e_busy  = (busy_left > 0) || starting;
    e_flush = excp_valid;
    e_pc    = excp_valid ? (excp_eret ? epc : VEC) : 32'h0;
    if (excp_valid)                 e_stall = 6'b000000;
    else if (stallreq_mem)          e_stall = 6'b011111;
    else if (stallreq_ex || e_busy) e_stall = 6'b001111;
    else if (stallreq_id)           e_stall = 6'b000111;
    else                            e_stall = 6'b000000;
  endtask

  task automatic model_advance();
`ifdef PIPE_CTRL_PERF_EN
    if (e_stall[0]) exp_stall_cnt++;
    if (e_flush)    exp_flush_cnt++;
`endif
    if (excp_valid)                              busy_left = 0;
    else if (busy_left > 0)                      busy_left--;
    else if (mc_start && (mc_len != 4'd0))       busy_left = int'(mc_len) - 1;
  endtask

  task automatic model_reset();
    busy_left = 0;
`ifdef PIPE_CTRL_PERF_EN
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
`endif
  endtask

  task automatic clear_inputs();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    mc_start = 0; mc_len = 0; excp_valid = 0; excp_eret = 0; epc = 0;
  endtask

  task automatic next_cycle();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Held in reset from time 0 with an EX request present.
    stallreq_ex = 1;
    @(negedge clk);
    total++;
    if (stall !== 6'b0 || busy !== 1'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold stall=%b busy=%b flush=%b pc=%h want 000000/0/0/0", stall, busy, flush, new_pc);
    end
    do_reset();
    // Start a long op, then assert reset between clock edges.
    mc_start = 1; mc_len = 4'd5;
    @(negedge clk); model_eval(); next_cycle();
    mc_start = 0; mc_len = 0; stallreq_ex = 1;
    #2 rst = 0;
    #1;
    total++;
    if (stall !== 6'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async stall=%b busy=%b want 000000/0", stall, busy);
    end
    model_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (stall !== 6'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_noresume stall=%b busy=%b want 000000/0", stall, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mc_len3();
    for (int c = 0; c < 5; c++) begin
      mc_start = (c == 0); mc_len = (c == 0) ? 4'd3 : 4'd0;
      @(negedge clk);
      model_eval();
      total++;
      if (stall !== e_stall || busy !== e_busy || stall !== ((c < 3) ? 6'b001111 : 6'b000000)) begin
        bad++;
        $display("FAIL mc_len3 c%0d stall=%b busy=%b want %b/%b", c, stall, busy, e_stall, e_busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_len_edges();
    logic [3:0] lens [3];
    lens[0] = 4'd0; lens[1] = 4'd1; lens[2] = 4'd15;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 17; c++) begin
        mc_start = (c == 0); mc_len = (c == 0) ? lens[k] : 4'd0;
        @(negedge clk);
        model_eval();
        total++;
        if (stall !== e_stall || busy !== e_busy) begin
          bad++;
          $display("FAIL len%0d c%0d stall=%b busy=%b want %b/%b", lens[k], c, stall, busy, e_stall, e_busy);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_priority();
    logic [5:0] want [3];
    want[0] = 6'b011111; want[1] = 6'b001111; want[2] = 6'b000111;
    stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) stallreq_mem = 0;
      if (s == 2) stallreq_ex = 0;
      @(negedge clk);
      model_eval();
      total++;
      if (stall !== want[s] || stall !== e_stall) begin
        bad++;
        $display("FAIL priority s%0d stall=%b want %b", s, stall, want[s]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_excp_mc();
    mc_start = 1; mc_len = 4'd3;
    @(negedge clk); model_eval(); next_cycle();
    mc_start = 0; mc_len = 0;
    excp_valid = 1; excp_eret = 0; stallreq_mem = 1;
    @(negedge clk);
    model_eval();
    total++;
    if (flush !== 1'b1 || new_pc !== 32'h20 || stall !== 6'b0) begin
      bad++;
      $display("FAIL excp_mc flush=%b pc=%h stall=%b want 1/00000020/000000", flush, new_pc, stall);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    model_eval();
    total++;
    if (busy !== 1'b0 || stall !== 6'b0 || flush !== 1'b0 || busy !== e_busy) begin
      bad++;
      $display("FAIL excp_after busy=%b stall=%b flush=%b want 0/000000/0", busy, stall, flush);
    end
    next_cycle();
  endtask

  task automatic test_eret();
    excp_valid = 1; excp_eret = 1; epc = 32'h0000_0104;
    mc_start = 1; mc_len = 4'd4;
    @(negedge clk);
    model_eval();
    total++;
    if (new_pc !== 32'h104 || flush !== 1'b1 || stall !== 6'b0) begin
      bad++;
      $display("FAIL eret pc=%h flush=%b stall=%b want 00000104/1/000000", new_pc, flush, stall);
    end
    next_cycle();
    clear_inputs();
    epc = 32'h0000_0104;
    @(negedge clk);
    model_eval();
    total++;
    if (new_pc !== 32'h0 || flush !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL eret_after pc=%h flush=%b busy=%b want 0/0/0", new_pc, flush, busy);
    end
    next_cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      stallreq_id  = ($urandom_range(0, 3) == 0);
      stallreq_ex  = ($urandom_range(0, 5) == 0);
      stallreq_mem = ($urandom_range(0, 4) == 0);
      mc_start     = ($urandom_range(0, 3) == 0);
      mc_len       = 4'($urandom_range(0, 15));
      excp_valid   = ($urandom_range(0, 19) == 0);
      excp_eret    = $urandom_range(0, 1) == 1;
      epc          = $urandom;
      @(negedge clk);
      model_eval();
      total++;
      if (stall !== e_stall || busy !== e_busy || flush !== e_flush || new_pc !== e_pc) begin
        bad++;
        $display("FAIL random c%0d stall=%b busy=%b flush=%b pc=%h want %b/%b/%b/%h",
                 c, stall, busy, flush, new_pc, e_stall, e_busy, e_flush, e_pc);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    do_reset();
    test_mc_len3();
    total++;
    if (perf_stall_cnt !== 32'd3) begin
      bad++;
      $display("FAIL perf_stall got=%0d want=3", perf_stall_cnt);
    end
    test_excp_mc();
    total++;
    if (perf_flush_cnt !== 32'd1) begin
      bad++;
      $display("FAIL perf_flush got=%0d want=1", perf_flush_cnt);
    end
    test_random();
    total++;
    if (perf_stall_cnt !== 32'(exp_stall_cnt) || perf_flush_cnt !== 32'(exp_flush_cnt)) begin
      bad++;
      $display("FAIL perf_random stall=%0d flush=%0d want %0d/%0d",
               perf_stall_cnt, perf_flush_cnt, exp_stall_cnt, exp_flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mc_len3();
    test_len_edges();
    test_priority();
    test_excp_mc();
    test_eret();
    test_random();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
